// File: rtl/delay_pkg.sv
// Shared types and constants for the programmable delay timer.
package delay_pkg;

    // FSM state encoding
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } delay_state_t;

    // Operating mode, sampled together with start
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/delay_down_counter.sv
// Loadable WIDTH-bit down-counter with clear and a zero flag.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       load count from load_val (below clear in priority)
//   dec        decrement by one; saturates at zero
//   clear      force count to zero (highest after rst)
//   load_val   value loaded on load
//   count      registered remaining count
//   zero_c     combinational decode of count == 0
module delay_down_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    // Count register; the dec guard keeps count from wrapping below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/delay_timer.sv
// Programmable periodic / one-shot delay timer, single clock domain.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load period and mode, enter RUN (restarts when already running)
//   stop       abort to IDLE without tick or done; sq_out holds
//   mode       0 = periodic, 1 = one-shot (sampled with start)
//   load_val   period in cycles, 0 treated as 1 (sampled with start)
//   busy       high while in RUN
//   tick       one-cycle pulse per expiry
//   done       one-cycle pulse on one-shot expiry
//   sq_out     toggles on every expiry
//   count      remaining count
module delay_timer
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             sq_out,
    output logic [WIDTH-1:0] count
);

    delay_state_t     state;
    delay_state_t     state_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] pe_m1_c;
    logic [WIDTH-1:0] cnt_val_c;
    logic             cnt_load_c;
    logic             cnt_dec_c;
    logic             cnt_clear_c;
    logic             cnt_zero_c;
    logic             tick_nxt;
    logic             done_nxt;
    logic             sq_nxt;

    // Pe - 1, with load_val == 0 treated as Pe = 1 so it never wraps
    assign pe_m1_c = (load_val == '0) ? '0 : (load_val - WIDTH'(1));

    delay_down_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .dec      (cnt_dec_c),
        .clear    (cnt_clear_c),
        .load_val (cnt_val_c),
        .count    (count),
        .zero_c   (cnt_zero_c)
    );

    // State register plus registered outputs and captured mode/period
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= MODE_PERIODIC;
            reload_q <= '0;
            busy     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            sq_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            reload_q <= reload_nxt;
            busy     <= (state_nxt == RUN);
            tick     <= tick_nxt;
            done     <= done_nxt;
            sq_out   <= sq_nxt;
        end
    end

    // Next state: stop > start > one-shot expiry
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end else if ((state == RUN) && cnt_zero_c && (mode_q == MODE_ONESHOT)) begin
            state_nxt = IDLE;
        end
    end

    // Counter control and next values of the registered outputs
    always_comb begin
        cnt_load_c  = 1'b0;
        cnt_dec_c   = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_val_c   = reload_q;
        mode_nxt    = mode_q;
        reload_nxt  = reload_q;
        tick_nxt    = 1'b0;
        done_nxt    = 1'b0;
        sq_nxt      = sq_out;
        if (stop) begin
            cnt_clear_c = 1'b1;
        end else if (start) begin
            // restart suppresses any expiry on this edge
            cnt_load_c = 1'b1;
            cnt_val_c  = pe_m1_c;
            mode_nxt   = mode;
            reload_nxt = pe_m1_c;
        end else if (state == RUN) begin
            if (cnt_zero_c) begin
                tick_nxt = 1'b1;
                sq_nxt   = ~sq_out;
                if (mode_q == MODE_PERIODIC) begin
                    cnt_load_c = 1'b1;
                end else begin
                    done_nxt = 1'b1;
                end
            end else begin
                cnt_dec_c = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer (WIDTH = 6): the stimulus process queues
// expected output snapshots and expected expiry edges; the monitor pops and
// compares on the falling edge whenever a snapshot is due or tick/done is seen.
module tb_delay_timer;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] load_val;
    logic         busy;
    logic         tick;
    logic         done;
    logic         sq_out;
    logic [W-1:0] count;

    typedef struct {
        int           id;
        logic         b;
        logic         t;
        logic         d;
        logic         s;
        logic [W-1:0] c;
    } snap_t;

    typedef struct {
        int   e;
        logic d;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    snap_t sx;
    ev_t   ey;
    int    sid    = 0;
    int    edge_n = 0;
    int    total  = 0;
    int    bad    = 0;
    logic  end_req = 1'b0;

    delay_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .sq_out   (sq_out),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // One edge with the given inputs; pulses are dropped afterwards
    task automatic drive(input logic r, input logic s, input logic p,
                         input logic m, input logic [W-1:0] lv);
        rst = r; start = s; stop = p; mode = m; load_val = lv;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, mode, load_val);
    endtask

    task automatic exp_s(input logic b, input logic t, input logic d,
                         input logic s, input logic [W-1:0] c);
        snap_q.push_back('{sid, b, t, d, s, c});
        sid++;
    endtask

    task automatic exp_ev(input int e, input logic d);
        ev_q.push_back('{e, d});
    endtask

    // Monitor: sole owner of the pass/fail counters
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            sx = snap_q.pop_front();
            total++;
            if ({busy, tick, done, sq_out, count} !== {sx.b, sx.t, sx.d, sx.s, sx.c}) begin
                bad++;
                $display("FAIL snap%0d edge=%0d got busy=%b tick=%b done=%b sq=%b count=%0d want busy=%b tick=%b done=%b sq=%b count=%0d",
                         sx.id, edge_n, busy, tick, done, sq_out, count, sx.b, sx.t, sx.d, sx.s, sx.c);
            end
        end
        if ((tick === 1'b1) || (done === 1'b1)) begin
            total++;
            if (ev_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_expiry edge=%0d tick=%b done=%b want none", edge_n, tick, done);
            end else begin
                ey = ev_q.pop_front();
                if ((ey.e != edge_n) || (ey.d !== done) || (tick !== 1'b1)) begin
                    bad++;
                    $display("FAIL expiry edge=%0d tick=%b done=%b want edge=%0d tick=1 done=%b",
                             edge_n, tick, done, ey.e, ey.d);
                end
            end
        end
        if (end_req) begin
            total++;
            if ((ev_q.size() != 0) || (snap_q.size() != 0)) begin
                bad++;
                $display("FAIL leftover events=%0d snaps=%0d want 0 0", ev_q.size(), snap_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; load_val = '0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0); exp_s(0, 0, 0, 0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0); exp_s(0, 0, 0, 0, 6'd0);

        // Reset mid-run: periodic Pe=10, reset at count 4
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd10); exp_s(1, 0, 0, 0, 6'd9);
        for (int i = 1; i <= 5; i++) idle();
        exp_s(1, 0, 0, 0, 6'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd10); exp_s(0, 0, 0, 0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd10); exp_s(0, 0, 0, 0, 6'd0);
        for (int i = 0; i < 15; i++) begin idle(); exp_s(0, 0, 0, 0, 6'd0); end

        // Periodic 32: ticks at +32, +64, +96, sq_out = clk/64
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd32); k = edge_n;
        exp_s(1, 0, 0, 0, 6'd31);
        exp_ev(k + 32, 1'b0); exp_ev(k + 64, 1'b0); exp_ev(k + 96, 1'b0);
        for (int i = 1; i <= 96; i++) begin
            idle();
            case (i)
                31: exp_s(1, 0, 0, 0, 6'd0);
                32: exp_s(1, 1, 0, 1, 6'd31);
                33: exp_s(1, 0, 0, 1, 6'd30);
                63: exp_s(1, 0, 0, 1, 6'd0);
                64: exp_s(1, 1, 0, 0, 6'd31);
                96: exp_s(1, 1, 0, 1, 6'd31);
                default: ;
            endcase
        end
        // Reset clears a set sq_out
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0); exp_s(0, 0, 0, 0, 6'd0);

        // One-shot 5, then one-shot 2 started while done is high
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd5); k = edge_n;
        exp_s(1, 0, 0, 0, 6'd4); exp_ev(k + 5, 1'b1);
        for (int i = 1; i <= 4; i++) begin idle(); exp_s(1, 0, 0, 0, 6'(4 - i)); end
        idle(); exp_s(0, 1, 1, 1, 6'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd2); k = edge_n;
        exp_s(1, 0, 0, 1, 6'd1); exp_ev(k + 2, 1'b1);
        idle(); exp_s(1, 0, 0, 1, 6'd0);
        idle(); exp_s(0, 1, 1, 0, 6'd0);
        for (int i = 0; i < 20; i++) begin idle(); exp_s(0, 0, 0, 0, 6'd0); end

        // load_val 0 and 1 periodic: continuous tick, sq_out every cycle
        for (int lv = 0; lv <= 1; lv++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 6'(lv)); k = edge_n;
            exp_s(1, 0, 0, 0, 6'd0);
            for (int i = 1; i <= 8; i++) exp_ev(k + i, 1'b0);
            for (int i = 1; i <= 8; i++) begin idle(); exp_s(1, 1, 0, 1'(i % 2), 6'd0); end
            drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0); exp_s(0, 0, 0, 0, 6'd0);
        end

        // start+stop at count 0: stop wins, no expiry
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd3); exp_s(1, 0, 0, 0, 6'd2);
        idle(); exp_s(1, 0, 0, 0, 6'd1);
        idle(); exp_s(1, 0, 0, 0, 6'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd3); exp_s(0, 0, 0, 0, 6'd0);
        for (int i = 0; i < 3; i++) begin idle(); exp_s(0, 0, 0, 0, 6'd0); end

        // start alone at count 0: reload, no tick that edge
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd3); exp_s(1, 0, 0, 0, 6'd2);
        idle(); idle(); exp_s(1, 0, 0, 0, 6'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd4); k = edge_n;
        exp_s(1, 0, 0, 0, 6'd3); exp_ev(k + 4, 1'b0);
        idle(); exp_s(1, 0, 0, 0, 6'd2);
        idle(); exp_s(1, 0, 0, 0, 6'd1);
        idle(); exp_s(1, 0, 0, 0, 6'd0);
        idle(); exp_s(1, 1, 0, 1, 6'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0); exp_s(0, 0, 0, 1, 6'd0);

        // Restart periodic Pe=8 at count 5 as one-shot 3
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd8); exp_s(1, 0, 0, 1, 6'd7);
        idle(); idle(); exp_s(1, 0, 0, 1, 6'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd3); k = edge_n;
        exp_s(1, 0, 0, 1, 6'd2); exp_ev(k + 3, 1'b1);
        idle(); exp_s(1, 0, 0, 1, 6'd1);
        idle(); exp_s(1, 0, 0, 1, 6'd0);
        idle(); exp_s(0, 1, 1, 0, 6'd0);
        for (int i = 0; i < 6; i++) begin idle(); exp_s(0, 0, 0, 0, 6'd0); end

        // Maximum period 2^W-1 = 63, one-shot
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'd63); k = edge_n;
        exp_s(1, 0, 0, 0, 6'd62); exp_ev(k + 63, 1'b1);
        for (int i = 1; i <= 62; i++) begin
            idle();
            if (i == 1)  exp_s(1, 0, 0, 0, 6'd61);
            if (i == 62) exp_s(1, 0, 0, 0, 6'd0);
        end
        idle(); exp_s(0, 1, 1, 1, 6'd0);
        idle(); exp_s(0, 0, 0, 1, 6'd0);

        idle();
        end_req = 1'b1;
        @(negedge clk);
        #1;
    end

endmodule

// File: doc/delay_timer.md
# delay_timer

Parametrised, synchronous successor to the fixed divide-by-64 ripple delay chain. It runs a WIDTH-bit programmable down-counter in one clock domain and supports two modes: periodic, which produces a tick and square wave, and one-shot, which produces a delay with a done pulse. Start and stop are controlled by a simple handshake. It sits between control FSMs and anything needing timed waits or slow enables, with no derived clocks.

## Interface

Parameters:
- WIDTH, 16, counter and load width; legal range 2–32.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; loads period and mode, enters RUN.
- stop  in  1  abort; returns to IDLE without tick or done.
- mode  in  1  0 = periodic, 1 = one-shot; sampled only with start.
- load_val  in  WIDTH  period P, in cycles; sampled only with start.
- busy  out  1  high while in RUN.
- tick  out  1  one-cycle pulse on every expiry, in both modes.
- done  out  1  one-cycle pulse on one-shot expiry only.
- sq_out  out  1  toggles on every expiry; periodic mode gives clk/(2P).
- count  out  WIDTH  current remaining count.

## Operation

**States:** IDLE, RUN.

**Effective period:**
- Pe = load_val, except load_val == 0 gives Pe = 1.
- Pe, mode and the period register are captured together with start.

**Priority at each edge, highest first:** rst > stop > start > expiry > decrement.

**rst:**
- State goes to IDLE.
- count, busy, tick, done and sq_out all go to 0.
- Applies immediately, including mid-run.

**stop (state = RUN or IDLE):**
- State goes to IDLE and count to 0.
- tick and done are 0.
- sq_out holds its value.

**start, when stop = 0:**
- State goes to RUN.
- count loads Pe−1; the mode and period registers are loaded.
- In RUN this is a restart: no expiry is generated that edge, even when count = 0.

**RUN with count ≠ 0:** count decrements by 1; tick and done are 0.

**RUN with count = 0 (expiry):**
- tick goes to 1 and sq_out toggles.
- Periodic mode: count reloads Pe−1 and the state stays RUN.
- One-shot mode: state goes to IDLE, count stays 0, and done goes to 1.

**IDLE without start:** all outputs hold, except tick and done, which are 0.

**Width rules:**
- count never underflows.
- Pe−1 is computed in WIDTH bits; Pe ≥ 1 guarantees no wrap.
- Maximum period is 2^WIDTH−1.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Start sampled at edge k: the first expiry registers at edge k+Pe, so tick and done are high during the cycle after edge k+Pe.
- Periodic mode: subsequent ticks follow every Pe edges, and the tick duty cycle is 1/Pe.
- busy:
  - rises at edge k;
  - in one-shot mode, falls at the same edge that sets done;
  - falls at the edge that samples stop.
- Pe = 1 in periodic mode: tick stays high continuously from edge k+1, and sq_out toggles every cycle (clk/2).
- One-shot start while done is high is accepted normally. The next done occurs Pe edges later.

## Structure

- Package delay_pkg holds:
  - typedef delay_state_t {IDLE, RUN};
  - constants MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1.
- Sub-module delay_down_counter: WIDTH-bit loadable down-counter with load, dec and clear inputs and a zero flag.
- The top level holds the FSM, the mode and period registers, and the tick, done and sq_out registers.

## Test plan

1. **Reset mid-run:** periodic mode, Pe = 10; assert rst for 2 cycles at count = 4 → next edge gives busy = 0, count = 0, tick = 0, done = 0, sq_out = 0; no activity afterwards until start.
2. **Periodic, WIDTH = 6, load_val = 32:** start at edge 0 → tick is high after edges 32, 64 and 96. sq_out rises at edge 32, falls at 64 and rises at 96, i.e. clk/64, matching the legacy divider.
3. **One-shot, load_val = 5:** start at edge 0 → single done and tick pulse after edge 5; busy falls at edge 5; count reads 4, 3, 2, 1, 0; no further pulses over the next 20 cycles.
4. **load_val = 0 and load_val = 1, periodic:** tick is high continuously from edge 1; sq_out toggles every cycle; both cases behave identically.
5. **Simultaneous events:**
   - start and stop at the edge where count = 0 → IDLE, no tick, no done, sq_out unchanged.
   - start alone at count = 0 → reload, no tick that edge.
6. **Restart:** periodic mode, Pe = 8; at count = 5, start with load_val = 3 and mode = one-shot → done after edge restart+3; no tick from the old period.
